// File: rtl/mk_xsim_top.sv
// Portal core: inner-product accumulator (clear / multiply-accumulate / read back) over 32-bit ready/ready beat streams.
// Ready/valid outputs decode straight from registered state; responses stall until the host accepts.
module mk_xsim_top (
    input  logic        CLK,
    input  logic        RST_N,
    output logic        msgSink_dst_rdy,
    input  logic        msgSink_src_rdy_b,
    input  logic [31:0] msgSink_beat_v,
    output logic        msgSource_src_rdy,
    input  logic        msgSource_dst_rdy_b,
    output logic [31:0] msgSource_beat,
    output logic        CLK_singleClock,
    output logic        CLK_GATE_singleClock,
    output logic        RST_N_singleReset
);

    typedef enum logic [1:0] {
        ST_HDR       = 2'd0,
        ST_PAYLOAD   = 2'd1,
        ST_RESP_HDR  = 2'd2,
        ST_RESP_DATA = 2'd3
    } state_t;

    localparam logic [15:0] METH_CLEAR = 16'd0;
    localparam logic [15:0] METH_MAC   = 16'd1;
    localparam logic [15:0] METH_READ  = 16'd2;

    state_t      state_q, state_d;
    logic [31:0] acc_q, acc_d;
    logic [15:0] rem_q, rem_d;
    logic [15:0] meth_q, meth_d;
    logic        first_q, first_d;

    logic        sink_fire;
    logic        src_fire;
    logic [15:0] hdr_meth;
    logic [15:0] hdr_len;
    logic signed [31:0] prod;

    assign CLK_singleClock      = CLK;
    assign CLK_GATE_singleClock = 1'b1;
    assign RST_N_singleReset    = RST_N;

    // Outputs are forced low while reset is held, independent of state.
    assign msgSink_dst_rdy   = RST_N && (state_q == ST_HDR || state_q == ST_PAYLOAD);
    assign msgSource_src_rdy = RST_N && (state_q == ST_RESP_HDR || state_q == ST_RESP_DATA);
    assign msgSource_beat    = !msgSource_src_rdy     ? 32'd0 :
                               (state_q == ST_RESP_HDR) ? 32'h0000_0002 : acc_q;

    assign sink_fire = msgSink_dst_rdy && msgSink_src_rdy_b;
    assign src_fire  = msgSource_src_rdy && msgSource_dst_rdy_b;
    assign hdr_meth  = msgSink_beat_v[31:16];
    assign hdr_len   = msgSink_beat_v[15:0];
    assign prod      = $signed(msgSink_beat_v[31:16]) * $signed(msgSink_beat_v[15:0]);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        meth_d  = meth_q;
        first_d = first_q;
        case (state_q)
            ST_HDR: begin
                if (sink_fire) begin
                    if (hdr_meth == METH_CLEAR) begin
                        acc_d = 32'd0;
                    end
                    if (hdr_len > 16'd1) begin
                        rem_d   = hdr_len - 16'd1;
                        meth_d  = hdr_meth;
                        first_d = 1'b1;
                        state_d = ST_PAYLOAD;
                    end else if (hdr_meth == METH_READ) begin
                        state_d = ST_RESP_HDR;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (sink_fire) begin
                    rem_d   = rem_q - 16'd1;
                    first_d = 1'b0;
                    // Only the first payload beat of a MAC contributes; the rest are dropped.
                    if (meth_q == METH_MAC && first_q) begin
                        acc_d = acc_q + $unsigned(prod);
                    end
                    if (rem_q == 16'd1) begin
                        state_d = (meth_q == METH_READ) ? ST_RESP_HDR : ST_HDR;
                    end
                end
            end
            ST_RESP_HDR: begin
                if (src_fire) begin
                    state_d = ST_RESP_DATA;
                end
            end
            ST_RESP_DATA: begin
                if (src_fire) begin
                    state_d = ST_HDR;
                end
            end
            default: state_d = ST_HDR;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= ST_HDR;
            acc_q   <= 32'd0;
            rem_q   <= 16'd0;
            meth_q  <= 16'd0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            meth_q  <= meth_d;
            first_q <= first_d;
        end
    end

endmodule

// File: tb/tb_mk_xsim_top.sv
// Bench for mk_xsim_top: message-level accumulator model feeds an expectation queue; a monitor checks every response beat.
module tb_mk_xsim_top;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        msgSink_dst_rdy;
    logic        msgSink_src_rdy_b = 1'b0;
    logic [31:0] msgSink_beat_v = 32'd0;
    logic        msgSource_src_rdy;
    logic        msgSource_dst_rdy_b = 1'b0;
    logic [31:0] msgSource_beat;
    logic        CLK_singleClock;
    logic        CLK_GATE_singleClock;
    logic        RST_N_singleReset;

    mk_xsim_top dut (
        .CLK                  (CLK),
        .RST_N                (RST_N),
        .msgSink_dst_rdy      (msgSink_dst_rdy),
        .msgSink_src_rdy_b    (msgSink_src_rdy_b),
        .msgSink_beat_v       (msgSink_beat_v),
        .msgSource_src_rdy    (msgSource_src_rdy),
        .msgSource_dst_rdy_b  (msgSource_dst_rdy_b),
        .msgSource_beat       (msgSource_beat),
        .CLK_singleClock      (CLK_singleClock),
        .CLK_GATE_singleClock (CLK_GATE_singleClock),
        .RST_N_singleReset    (RST_N_singleReset)
    );

    always #5 CLK = ~CLK;

    int          n_cmp = 0;
    int          n_fail = 0;
    logic [31:0] exp_q[$];
    logic [31:0] model_acc = 32'd0;
    int          bp_mode = 0;   // 0 stall, 1 always ready, 2 random, 3 manual

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Host-side acceptance of response beats.
    always @(posedge CLK) begin
        #1;
        if (bp_mode == 0) msgSource_dst_rdy_b = 1'b0;
        else if (bp_mode == 1) msgSource_dst_rdy_b = 1'b1;
        else if (bp_mode == 2) msgSource_dst_rdy_b = ($urandom_range(0, 3) != 0);
    end

    // Monitor: a beat transfers on the next rising edge when both sides are ready.
    always @(negedge CLK) begin
        if (RST_N) begin
            if (!msgSource_src_rdy) check("idle_beat_zero", msgSource_beat, 32'd0);
            if (msgSource_src_rdy && msgSource_dst_rdy_b) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_resp", msgSource_beat, 32'hxxxx_xxxx);
                end else begin
                    check("resp_beat", msgSource_beat, exp_q.pop_front());
                end
            end
        end
    end

    // Reference: applies one whole message to the accumulator and queues any response.
    task automatic model_msg(input logic [31:0] beats[$]);
        logic [15:0] meth;
        longint      a, b;
        meth = beats[0][31:16];
        if (meth == 16'd0) model_acc = 32'd0;
        if (meth == 16'd1 && beats.size() > 1) begin
            a = longint'($signed(beats[1][31:16]));
            b = longint'($signed(beats[1][15:0]));
            model_acc = model_acc + 32'(a * b);
        end
        if (meth == 16'd2) begin
            exp_q.push_back(32'h0000_0002);
            exp_q.push_back(model_acc);
        end
    endtask

    task automatic send_beat(input logic [31:0] b);
        bit ok;
        ok = 1'b0;
        msgSink_src_rdy_b = 1'b1;
        msgSink_beat_v    = b;
        for (int i = 0; i < 400; i++) begin
            @(negedge CLK);
            if (msgSink_dst_rdy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("sink_timeout", 32'd0, 32'd1);
        @(posedge CLK);
        #1;
        msgSink_src_rdy_b = 1'b0;
        msgSink_beat_v    = $urandom;
    endtask

    task automatic send_msg(input logic [31:0] beats[$]);
        model_msg(beats);
        foreach (beats[i]) send_beat(beats[i]);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    logic [31:0] m[$];

    initial begin
        bp_mode = 1;
        // Reset held for 10 cycles.
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            check("rst_sink_rdy", {31'd0, msgSink_dst_rdy}, 32'd0);
            check("rst_src_rdy", {31'd0, msgSource_src_rdy}, 32'd0);
            check("rst_beat", msgSource_beat, 32'd0);
        end
        check("clk_gate", {31'd0, CLK_GATE_singleClock}, 32'd1);
        check("rst_passthru_low", {31'd0, RST_N_singleReset}, {31'd0, RST_N});
        check("clk_passthru_low", {31'd0, CLK_singleClock}, {31'd0, CLK});
        @(posedge CLK);
        #1;
        check("clk_passthru_high", {31'd0, CLK_singleClock}, {31'd0, CLK});
        RST_N = 1'b1;
        @(negedge CLK);
        check("rst_passthru_high", {31'd0, RST_N_singleReset}, 32'd1);
        check("sink_rdy_after_rst", {31'd0, msgSink_dst_rdy}, 32'd1);
        @(posedge CLK);
        #1;

        // Clear, two MACs (3*4 + -2*5 = 2), read.
        m = '{32'h0000_0001};                 send_msg(m);
        m = '{32'h0001_0002, 32'h0003_0004};  send_msg(m);
        m = '{32'h0001_0002, 32'hFFFE_0005};  send_msg(m);
        m = '{32'h0002_0001};                 send_msg(m);
        wait_cycles(4);

        // Response back-pressure for 5 cycles.
        bp_mode = 3;
        msgSource_dst_rdy_b = 1'b0;
        m = '{32'h0002_0001};
        send_msg(m);
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            check("bp_beat_held", msgSource_beat, 32'h0000_0002);
            check("bp_src_rdy", {31'd0, msgSource_src_rdy}, 32'd1);
            check("bp_sink_rdy", {31'd0, msgSink_dst_rdy}, 32'd0);
        end
        @(posedge CLK);
        #1;
        bp_mode = 1;
        msgSource_dst_rdy_b = 1'b1;
        @(negedge CLK);
        check("bp_rel_hdr_vld", {31'd0, msgSource_src_rdy}, 32'd1);
        @(negedge CLK);
        check("bp_rel_dat_vld", {31'd0, msgSource_src_rdy}, 32'd1);
        @(negedge CLK);
        check("bp_rel_done", {31'd0, msgSource_src_rdy}, 32'd0);
        @(posedge CLK);
        #1;

        // Wrap-around: 3 x 0x7FFF*0x7FFF.
        m = '{32'h0000_0001}; send_msg(m);
        for (int i = 0; i < 3; i++) begin
            m = '{32'h0001_0002, 32'h7FFF_7FFF};
            send_msg(m);
        end
        check("wrap_model", model_acc, 32'hBFFD_0003);
        m = '{32'h0002_0001}; send_msg(m);

        // Unknown method with payload leaves acc alone.
        m = '{32'h0007_0003, 32'h0005_0005, 32'h0009_0009}; send_msg(m);
        m = '{32'h0002_0001}; send_msg(m);
        wait_cycles(6);

        // Reset in the middle of a response.
        bp_mode = 3;
        msgSource_dst_rdy_b = 1'b0;
        m = '{32'h0001_0002, 32'h0011_0003}; send_msg(m);
        exp_q.push_back(32'h0000_0002);
        m = '{32'h0002_0001};
        foreach (m[i]) send_beat(m[i]);
        msgSource_dst_rdy_b = 1'b1;
        @(posedge CLK);
        #1;
        msgSource_dst_rdy_b = 1'b0;
        @(negedge CLK);
        check("mid_data_vld", {31'd0, msgSource_src_rdy}, 32'd1);
        check("mid_data_beat", msgSource_beat, model_acc);
        @(posedge CLK);
        #1;
        RST_N = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            check("mid_rst_src_rdy", {31'd0, msgSource_src_rdy}, 32'd0);
            check("mid_rst_beat", msgSource_beat, 32'd0);
        end
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        model_acc = 32'd0;
        bp_mode = 1;
        m = '{32'h0002_0001}; send_msg(m);

        // Random traffic under random back-pressure.
        bp_mode = 2;
        for (int k = 0; k < 60; k++) begin
            int          sel;
            logic [15:0] meth, lenf;
            int          n;
            sel  = $urandom_range(0, 6);
            meth = (sel == 0) ? 16'd0 : (sel <= 3) ? 16'd1 : (sel <= 5) ? 16'd2 : 16'($urandom_range(3, 9));
            lenf = 16'($urandom_range(0, 4));
            n    = (lenf == 16'd0) ? 1 : int'(lenf);
            m = '{};
            m.push_back({meth, lenf});
            for (int j = 1; j < n; j++) m.push_back($urandom);
            send_msg(m);
            if ($urandom_range(0, 3) == 0) wait_cycles($urandom_range(1, 3));
        end
        m = '{32'h0002_0001}; send_msg(m);

        for (int i = 0; i < 500 && exp_q.size() != 0; i++) @(posedge CLK);
        wait_cycles(2);
        check("drain_queue_empty", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
